// File: rtl/frb_pkg.sv
// rtl/frb_pkg.sv - shared types and constants for the FRB time-integration detector
// Purpose: detector FSM state encoding, accumulator width derivation, default gains.
// Ports: none (package).
package frb_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } frb_state_t;

  localparam int DEF_ALPHA_SHIFT = 4;
  localparam int DEF_CNT_WIDTH   = 16;

  // A window of up to 2^len_width-1 samples of in_width bits never overflows this width.
  function automatic int acc_width(input int in_width, input int len_width);
    return in_width + len_width;
  endfunction

endpackage

// File: rtl/frb_ema_baseline.sv
// rtl/frb_ema_baseline.sv - exponential-moving-average baseline register
// Purpose: holds the window-sum baseline; load copies sum, update moves the
//   baseline 2^-ALPHA_SHIFT of the way towards sum, otherwise it holds.
// Ports: clk, rst (sync active-high), load, update, sum[ACC_WIDTH], baseline[ACC_WIDTH].
module frb_ema_baseline
  import frb_pkg::*;
#(
  parameter int ACC_WIDTH   = 30,
  parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 update,
  input  logic [ACC_WIDTH-1:0] sum,
  output logic [ACC_WIDTH-1:0] baseline
);

  logic signed [ACC_WIDTH:0] diff;
  logic signed [ACC_WIDTH:0] step;

  // One extra bit keeps the difference exact; the arithmetic shift floors
  // negative steps, so a falling baseline moves by at least one LSB.
  assign diff = $signed({1'b0, sum}) - $signed({1'b0, baseline});
  assign step = diff >>> ALPHA_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      baseline <= '0;
    end else if (load) begin
      baseline <= sum;
    end else if (update) begin
      // Modular add of the truncated two's-complement step.
      baseline <= baseline + step[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/frb_time_integration_detector.sv
// rtl/frb_time_integration_detector.sv - windowed integration and FRB candidate trigger
// Purpose: sums int_len valid samples per window, tracks an EMA baseline of
//   window sums and pulses trigger when a sum exceeds baseline + thr, then
//   suppresses holdoff_len windows.
// Ports: clk_data, rst (sync active-high); data_in/data_in_valid sample stream;
//   int_len, thr, holdoff_len runtime controls; sum_out/sum_valid window result;
//   baseline_out, trigger, trig_cnt, armed status.
module frb_time_integration_detector
  import frb_pkg::*;
#(
  parameter int IN_WIDTH    = 22,
  parameter int LEN_WIDTH   = 8,
  parameter int ACC_WIDTH   = acc_width(IN_WIDTH, LEN_WIDTH),
  parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk_data,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_in_valid,
  input  logic [LEN_WIDTH-1:0] int_len,
  input  logic [ACC_WIDTH-1:0] thr,
  input  logic [7:0]           holdoff_len,
  output logic [ACC_WIDTH-1:0] sum_out,
  output logic                 sum_valid,
  output logic [ACC_WIDTH-1:0] baseline_out,
  output logic                 trigger,
  output logic [CNT_WIDTH-1:0] trig_cnt,
  output logic                 armed
);

  // ---------------- accumulate stage ----------------
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 last_sample;

  // The first sample of a window uses int_len directly; later samples use the
  // length latched at that first sample, so mid-window changes wait a window.
  always_comb begin
    cur_len = eff_len;
    if (count == '0) begin
      cur_len = (int_len == '0) ? LEN_WIDTH'(1) : int_len;
    end
    acc_next    = ((count == '0) ? '0 : acc) + ACC_WIDTH'(data_in);
    last_sample = ((count + LEN_WIDTH'(1)) == cur_len);
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      count     <= '0;
      eff_len   <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (data_in_valid) begin
        if (count == '0) begin
          eff_len <= cur_len;
        end
        acc <= acc_next;
        if (last_sample) begin
          sum_out   <= acc_next;
          sum_valid <= 1'b1;
          count     <= '0;
        end else begin
          count <= count + LEN_WIDTH'(1);
        end
      end
    end
  end

  // ---------------- decide stage ----------------
  frb_state_t             state;
  logic                   baseline_valid;
  logic [ALPHA_SHIFT-1:0] warm_cnt;
  logic [7:0]             hold_cnt;
  logic                   exceed;
  logic                   ema_load;
  logic                   ema_update;

  // Compared one bit wider so baseline + thr can never wrap.
  assign exceed = {1'b0, sum_out} > ({1'b0, baseline_out} + {1'b0, thr});

  assign ema_load   = sum_valid && (state == WARMUP) && !baseline_valid;
  assign ema_update = sum_valid && (((state == WARMUP) && baseline_valid) ||
                                    ((state == ARMED) && !exceed));

  always_ff @(posedge clk_data) begin
    if (rst) begin
      state          <= WARMUP;
      baseline_valid <= 1'b0;
      warm_cnt       <= '0;
      hold_cnt       <= '0;
      trigger        <= 1'b0;
      trig_cnt       <= '0;
      armed          <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (sum_valid) begin
        case (state)
          WARMUP: begin
            baseline_valid <= 1'b1;
            warm_cnt       <= warm_cnt + 1'b1;
            if (&warm_cnt) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
          ARMED: begin
            if (exceed) begin
              trigger  <= 1'b1;
              hold_cnt <= holdoff_len;
              if (!(&trig_cnt)) begin
                trig_cnt <= trig_cnt + 1'b1;
              end
              if (holdoff_len != 8'd0) begin
                state <= HOLDOFF;
                armed <= 1'b0;
              end
            end
          end
          HOLDOFF: begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
          default: begin
            state <= WARMUP;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

  frb_ema_baseline #(
    .ACC_WIDTH  (ACC_WIDTH),
    .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_ema (
    .clk     (clk_data),
    .rst     (rst),
    .load    (ema_load),
    .update  (ema_update),
    .sum     (sum_out),
    .baseline(baseline_out)
  );

endmodule

// File: tb/tb_frb_time_integration_detector.sv
// tb/tb_frb_time_integration_detector.sv - scoreboard bench for the FRB detector
module tb_frb_time_integration_detector;

  logic        clk_data = 1'b0;
  logic        rst;
  logic [21:0] data_in;
  logic        data_in_valid;
  logic [7:0]  int_len;
  logic [29:0] thr;
  logic [7:0]  holdoff_len;
  logic [29:0] sum_out;
  logic        sum_valid;
  logic [29:0] baseline_out;
  logic        trigger;
  logic [15:0] trig_cnt;
  logic        armed;

  always #5 clk_data = ~clk_data;

  frb_time_integration_detector dut (
    .clk_data     (clk_data),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .int_len      (int_len),
    .thr          (thr),
    .holdoff_len  (holdoff_len),
    .sum_out      (sum_out),
    .sum_valid    (sum_valid),
    .baseline_out (baseline_out),
    .trigger      (trigger),
    .trig_cnt     (trig_cnt),
    .armed        (armed)
  );

  typedef struct {
    longint sum;
    logic   trig;
    longint base;
    longint cnt;
    logic   arm;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur;
  bit     pending = 1'b0;
  int     checks = 0;
  int     errors = 0;

  // reference model state
  int     m_state;   // 0 warmup, 1 armed, 2 holdoff
  longint m_base;
  bit     m_bv;
  int     m_warm;
  int     m_hold;
  longint m_tcnt;
  int     m_count;
  int     m_len;
  longint m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint ema(input longint b, input longint s);
    longint d;
    longint q;
    d = s - b;
    if (d >= 0) q = d / 16;
    else        q = -((-d + 15) / 16);
    return (b + q) & 64'h3FFF_FFFF;
  endfunction

  task automatic model_reset();
    m_state = 0; m_base = 0; m_bv = 0; m_warm = 0; m_hold = 0;
    m_tcnt = 0; m_count = 0; m_len = 1; m_acc = 0;
  endtask

  task automatic model_window(input longint s);
    exp_t e;
    e.sum  = s;
    e.trig = 1'b0;
    case (m_state)
      0: begin
        if (!m_bv) m_base = s;
        else       m_base = ema(m_base, s);
        m_bv = 1;
        m_warm++;
        if (m_warm == 16) m_state = 1;
      end
      1: begin
        if (s > m_base + longint'(thr)) begin
          e.trig = 1'b1;
          if (m_tcnt < 65535) m_tcnt++;
          if (holdoff_len != 0) begin
            m_hold  = holdoff_len;
            m_state = 2;
          end
        end else begin
          m_base = ema(m_base, s);
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_state = 1;
      end
    endcase
    e.base = m_base;
    e.cnt  = m_tcnt;
    e.arm  = (m_state == 1);
    sb.push_back(e);
  endtask

  task automatic send(input int v, input int gap);
    data_in       = 22'(v);
    data_in_valid = 1'b1;
    if (m_count == 0) m_len = (int_len == 0) ? 1 : int_len;
    m_acc = ((m_count == 0) ? 0 : m_acc) + v;
    m_count++;
    if (m_count == m_len) begin
      m_count = 0;
      model_window(m_acc);
    end
    @(posedge clk_data); #1;
    data_in_valid = 1'b0;
    data_in       = '0;
    repeat (gap) begin
      @(posedge clk_data); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_data); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sum_out"}, sum_out, 0);
    chk({tag, "_sum_valid"}, sum_valid, 0);
    chk({tag, "_baseline"}, baseline_out, 0);
    chk({tag, "_trigger"}, trigger, 0);
    chk({tag, "_trig_cnt"}, trig_cnt, 0);
    chk({tag, "_armed"}, armed, 0);
  endtask

  task automatic do_reset(input string tag);
    idle(3);
    rst = 1'b1;
    @(posedge clk_data);
    @(negedge clk_data);
    check_zero(tag);
    sb.delete();
    model_reset();
    @(posedge clk_data); #1;
    rst = 1'b0;
  endtask

  task automatic warmup_100();
    for (int w = 0; w < 16; w++) send(100, 0);
    idle(3);
  endtask

  // Monitor: sum checked on sum_valid, decision outputs checked the next cycle.
  always @(negedge clk_data) begin
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        chk("trigger", trigger, cur.trig);
        chk("baseline", baseline_out, cur.base);
        chk("trig_cnt", trig_cnt, cur.cnt);
        chk("armed", armed, cur.arm);
        pending = 1'b0;
      end else begin
        chk("no_spurious_trigger", trigger, 0);
      end
      if (sum_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_sum_valid observed=%0d expected=none", sum_out);
        end else begin
          cur = sb.pop_front();
          chk("sum_out", sum_out, cur.sum);
          pending = 1'b1;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    int_len       = 8'd4;
    thr           = 30'd50;
    holdoff_len   = 8'd0;
    model_reset();
    repeat (2) @(posedge clk_data);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(1);

    // int_len=4 with gaps; sum_valid must follow the 4th sample by one cycle
    send(1, 1);
    send(2, 2);
    send(3, 3);
    send(4, 0);
    chk("sum_valid_latency", sum_valid, 1);
    idle(2);
    // int_len=0 behaves as 1
    int_len = 8'd0;
    send(7, 1);
    send(7, 0);
    send(7, 2);

    // warmup never triggers even with a spike at window 5; back-to-back windows
    do_reset("rst_warm");
    int_len = 8'd1;
    for (int w = 1; w <= 16; w++) send((w == 5) ? 1000 : 100, 0);
    idle(3);
    chk("armed_after_warmup", armed, 1);

    // 150 is not above 100+50: EMA moves to 103
    do_reset("rst_a");
    warmup_100();
    send(150, 3);
    chk("baseline_103", baseline_out, 103);

    // 151 triggers; baseline holds; then EMA rounding both ways
    do_reset("rst_b");
    warmup_100();
    send(151, 3);
    chk("trig_cnt_1", trig_cnt, 1);
    send(116, 3);
    chk("baseline_101", baseline_out, 101);
    send(84, 3);
    chk("baseline_99", baseline_out, 99);

    // holdoff of 3 windows: of five spikes only 1st and 5th trigger
    do_reset("rst_c");
    warmup_100();
    holdoff_len = 8'd3;
    for (int w = 0; w < 5; w++) send(300, 1);
    idle(3);
    chk("trig_cnt_2", trig_cnt, 2);
    send(300, 3);
    chk("in_holdoff_armed", armed, 0);
    do_reset("rst_holdoff");

    // reset mid-window discards the 2 pre-reset samples
    int_len = 8'd4;
    send(5, 0);
    send(6, 0);
    do_reset("rst_midwin");
    for (int i = 0; i < 4; i++) send(1, 0);
    idle(3);
    chk("post_reset_baseline", baseline_out, 4);

    for (int i = 0; i < 20 && (sb.size() != 0 || pending); i++) idle(1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
